// File: rtl/inv_add_round_key_seq_if.sv
// Handshake bundle for inv_add_round_key_seq: key load, state input stream,
// round-key-XORed output stream and completion pulse.
interface inv_add_round_key_seq_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         state_valid;
    logic         state_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
    logic         done;

    modport master (
        output start, key_in, state_valid, state_in, out_ready,
        input  busy, state_ready, out_valid, out_state, out_round, out_last, done
    );

    modport slave (
        input  start, key_in, state_valid, state_in, out_ready,
        output busy, state_ready, out_valid, out_state, out_round, out_last, done
    );
endinterface

// File: rtl/inv_add_round_key_seq.sv
// Iterative AES-128 inverse AddRoundKey: XORs 11 states (round 10..0) with a key
// schedule walked backward on the fly. Define INV_ARK_OUTREG_EN for a registered output stage.
module inv_add_round_key_seq (
    input  logic                        clk,
    input  logic                        rst,
    inv_add_round_key_seq_if.slave      bus
);

    // Forward AES S-box, byte 0x00 in the top 8 bits.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t         state_q;
    fsm_t         state_d;
    logic [127:0] key_reg;
    logic [7:0]   rcon;
    logic [3:0]   round;
    logic         run;
    logic         xfer;
    logic         last_xfer;
    logic         done_q;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
        return (rc >> 1) ^ (rc[0] ? 8'h8d : 8'h00);
    endfunction

    // Recover round r-1 key words w0..w3 from round r words w4..w7.
    function automatic logic [127:0] key_step_back(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w4, w5, w6, w7;
        logic [31:0] p0, p1, p2, p3;
        w4 = k[127:96];
        w5 = k[95:64];
        w6 = k[63:32];
        w7 = k[31:0];
        p3 = w7 ^ w6;
        p2 = w6 ^ w5;
        p1 = w5 ^ w4;
        p0 = w4 ^ sub_word(rot_word(p3)) ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

    assign run       = (state_q == RUN);
    assign xfer      = bus.state_valid & bus.state_ready;
    assign last_xfer = xfer & (round == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Key schedule walker: held while stalled, frozen after the round-0 transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
            rcon    <= '0;
            round   <= '0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                key_reg <= bus.key_in;
                rcon    <= 8'h36;
                round   <= 4'd10;
            end
        end else if (xfer && (round != 4'd0)) begin
            key_reg <= key_step_back(key_reg, rcon);
            rcon    <= rcon_prev(rcon);
            round   <= round - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_xfer;
        end
    end

`ifdef INV_ARK_OUTREG_EN
    logic         vld_p1;
    logic [127:0] out_state_p1;
    logic [3:0]   out_round_p1;
    logic         out_last_p1;

    // Output stage boundary p0 -> p1: a new result may load while the old one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            out_state_p1 <= '0;
            out_round_p1 <= '0;
            out_last_p1  <= 1'b0;
        end else if (xfer) begin
            vld_p1       <= 1'b1;
            out_state_p1 <= bus.state_in ^ key_reg;
            out_round_p1 <= round;
            out_last_p1  <= (round == 4'd0);
        end else if (bus.out_ready) begin
            vld_p1       <= 1'b0;
        end
    end

    always_comb begin
        bus.busy        = run;
        bus.state_ready = run & (~vld_p1 | bus.out_ready);
        bus.out_valid   = vld_p1;
        bus.out_state   = out_state_p1;
        bus.out_round   = out_round_p1;
        bus.out_last    = out_last_p1;
        bus.done        = done_q;
    end
`else
    always_comb begin
        bus.busy        = run;
        bus.state_ready = run & bus.out_ready;
        bus.out_valid   = run & bus.state_valid;
        bus.out_state   = run ? (bus.state_in ^ key_reg) : '0;
        bus.out_round   = run ? round : '0;
        bus.out_last    = run & (round == 4'd0);
        bus.done        = done_q;
    end
`endif

endmodule

// File: doc/inv_add_round_key_seq.md
# inv_add_round_key_seq

Iterative inverse AddRoundKey engine for the AES-128 decryption datapath. It is loaded once with the final (round-10) round key and then accepts 11 states in order, round 10 down to round 0. It XORs each state with the current round key. After each accepted state it steps the key schedule backward by one round using inverse key expansion and a reverse Rcon walk. It sits after InvSubBytes/InvShiftRows (or at the ciphertext input, for round 10) and feeds InvMixColumns.

## Interface
- Parameters: none (AES-128 only; 10 rounds fixed).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; loads `key_in` when idle.
- `key_in`  in  128  round-10 key; [127:120] = byte 0, words w0..w3 = bytes 0-3, 4-7, 8-11, 12-15.
- `busy`  out  1  high from accepted `start` until the round-0 transfer.
- `state_valid`  in  1  upstream state available.
- `state_ready`  out  1  engine accepts state this cycle.
- `state_in`  in  128  state bytes, same byte order as the key.
- `out_valid`  out  1  `out_state` valid.
- `out_ready`  in  1  downstream accepts.
- `out_state`  out  128  `state_in` XOR current round key.
- `out_round`  out  4  round index of `out_state` (10..0).
- `out_last`  out  1  high with the round-0 result.
- `done`  out  1  one-cycle pulse after the round-0 transfer.

## Operation
- FSM states: IDLE and RUN.
- IDLE: `busy`=0, `state_ready`=0.
- IDLE to RUN: `start`=1 loads key_reg=`key_in`, rcon=0x36, round=10.
- RUN to IDLE: input transfer with round==0 (`state_valid & state_ready`). `done` pulses the next cycle.
- `start` while in RUN is ignored.
- Input transfer: out = `state_in` ^ key_reg, tagged with round. Then key_reg steps back, rcon steps back, round decrements.
- Backward key step, from current words w4..w7 to previous words w0..w3:
  - w3 = w7^w6
  - w2 = w6^w5
  - w1 = w5^w4
  - w0 = w4 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}
- RotWord is a left rotate by one byte. SubWord applies the forward AES S-box to all 4 bytes; the four lookups are combinational inside this block.
- Reverse Rcon: rcon_next = (rcon>>1) ^ (rcon[0] ? 8'h8D : 8'h00). The sequence is 36,1B,80,40,20,10,08,04,02,01.
- The key step after the round-0 transfer is don't-care; key_reg is left unchanged.
- All arithmetic is GF(2) bytewise XOR. There are no carries.

## Timing
- Reset values:
  - FSM=IDLE, round=0, rcon=0, key_reg=0.
  - `busy`=0, `state_ready`=0, `out_valid`=0, `out_state`=0, `out_round`=0, `out_last`=0, `done`=0.
- `start` sampled at edge N gives `busy`=1 and `state_ready` eligible at cycle N+1.
- Reset mid-operation: returns to IDLE on the next edge. Any pending output is discarded, and no `done` pulse occurs.
- Simultaneous `rst` and `start`: reset wins.
- Backpressure: holding `out_ready`=0 stalls indefinitely. Round, rcon and key_reg are stable while stalled.
- `done` and the round-0 output handshake are independent. `done` is not gated by `out_ready` in the registered mode.

## Configuration
- `INV_ARK_OUTREG_EN` defined: registered output stage.
  - `out_*` are registered; latency is 1 cycle from input transfer.
  - `state_ready` = RUN & (!`out_valid` | `out_ready`).
  - `out_valid` holds until `out_ready`, giving full throughput of 1 state/cycle.
- `INV_ARK_OUTREG_EN` undefined: combinational pass-through, 0-cycle latency.
  - `out_valid` = RUN & `state_valid`.
  - `state_ready` = RUN & `out_ready`.
  - `out_state` = `state_in` ^ key_reg.
  - `out_round` = round.
- Both modes produce an identical transfer sequence and identical `done` timing relative to the round-0 input transfer.

## Test plan
- FIPS-197 C.1 key expansion:
  - Stimulus: `start` with `key_in`=13111d7fe3944a17f307a78b4d2b30c5, then 11 states of all-zero, with `out_ready`=1.
  - Required response: round-9 output = 549932d1f08557681093ed9cbe2c974e; round-0 output = 000102030405060708090a0b0c0d0e0f, with `out_last`=1 and `done` pulsing.
- Round-10 XOR:
  - Stimulus: `state_in`=69c4e0d86a7b0430d8cdb78070b4c55a with the key above.
  - Required response: `out_state`=7ad5fda789ef4e272bca100b3d9ff59f, `out_round`=10.
- Backpressure:
  - Stimulus: `out_ready` random 50%, `state_valid` random.
  - Required response: exactly 11 outputs with `out_round` 10..0 in order, values matching the first scenario, and no drop or duplicate.
- Reset mid-run:
  - Stimulus: assert `rst` after round 6 has been accepted.
  - Required response: all outputs zero and `busy`=0 next cycle; a new `start` restarts at round 10 with correct keys.
- Start while busy:
  - Stimulus: pulse `start` with a different key in round 4.
  - Required response: ignored; remaining outputs use the original schedule.
- Run the benches both with and without `INV_ARK_OUTREG_EN`.
  - Required response: registered mode shows 1-cycle latency and 1 state/cycle throughput with `out_ready`=1.
